sram_serial_loader: RTL
=======================

# sram_serial_loader

Upstream input stage of the deconvolution kernel estimator. Deserializes the single-wire `serial_in` load stream, LSB first, into DATA_WIDTH-bit words. Each word is written with an auto-incrementing address into the phase/frequency-vector SRAM or the transfer-function coefficient SRAM. When `adc_bypass_en` is set, the word is instead latched into the ADC bypass register that replaces the ADC sample.

## Interface
- DATA_WIDTH, 16, word width / bits per serial word
- ADDR_WIDTH, 12, SRAM write address width
- PHASE_WORDS, 1275, capacity of phase/frequency-vector SRAM (select 2'b00)
- COEFF_WORDS, 4096, capacity of coefficient SRAM (select 2'b01), 2*DEPTH
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high; clears all state
- load_en  in  1  bit-valid; `serial_in` sampled on every edge where high
- serial_in  in  1  serial data, LSB of each word first
- sram_select  in  2  target: 00 phase, 01 coeff, 10/11 output SRAMs (not loadable)
- adc_bypass_en  in  1  route words to the bypass register; overrides sram_select
- phase_wr_en  out  1  one-cycle write strobe, phase SRAM
- coeff_wr_en  out  1  one-cycle write strobe, coefficient SRAM
- wr_addr  out  ADDR_WIDTH  write address, shared
- wr_data  out  DATA_WIDTH  write data, shared
- adc_bypass_data  out  DATA_WIDTH  last complete bypass word
- adc_bypass_valid  out  1  high once a bypass word has been captured
- load_overflow  out  1  sticky; a word targeted beyond capacity
- load_busy  out  1  high while a load burst is active

## Operation
- States: IDLE, SHIFT.
  - IDLE→SHIFT on the first edge with load_en=1. On that edge, latch the target from adc_bypass_en/sram_select and sample bit 0.
  - SHIFT→IDLE on the first edge with load_en=0. Bit counter and address return to 0 on that transition.
- Target is latched only at burst start. Changes to sram_select or adc_bypass_en during a burst are ignored.
- Shift register: shreg <= {serial_in, shreg[DATA_WIDTH-1:1]}. Bit counter runs 0..DATA_WIDTH-1 and wraps to 0.
- On the edge that samples bit DATA_WIDTH-1, the word {serial_in, shreg[DATA_WIDTH-1:1]} is complete:
  - Target 00 and addr < PHASE_WORDS: phase_wr_en=1, wr_data=word, wr_addr=addr; addr increments.
  - Target 01 and addr < COEFF_WORDS: coeff_wr_en=1 with the same data/address rules; addr increments.
  - Target 00/01 with addr ≥ capacity: no strobe, addr holds, load_overflow set.
  - Target 10/11: word discarded, no strobe, addr unchanged, no overflow.
  - Bypass target: adc_bypass_data=word, adc_bypass_valid=1, addr unchanged.
- Partial word: if load_en falls with the bit counter ≠ 0, the partial bits are discarded and nothing is written.
- adc_bypass_data is retained across bursts and is cleared only by rst.
- load_overflow is cleared only by rst.
- Address arithmetic is unsigned ADDR_WIDTH. COEFF_WORDS = 2^ADDR_WIDTH, so the final coefficient address is 4095, and the next word overflows rather than wrapping to 0.

## Timing
- Throughput: one bit per clock while load_en is high; one word per DATA_WIDTH clocks.
- Write latency: phase_wr_en/coeff_wr_en, wr_addr and wr_data are registered. They are valid for exactly one cycle, on the cycle after the edge that sampled bit DATA_WIDTH-1.
- wr_addr and wr_data hold their last value when no strobe is active.
- adc_bypass_data and adc_bypass_valid update one cycle after the final bypass bit is sampled.
- load_busy is 1 from the cycle after burst start until the cycle after load_en is sampled low.
- Reset values: all strobes 0, wr_addr 0, wr_data 0, adc_bypass_data 0, adc_bypass_valid 0, load_overflow 0, load_busy 0, state IDLE.
- rst mid-burst aborts immediately:
  - Any pending strobe is suppressed.
  - After rst falls, loading resumes only on a fresh load_en burst; load_en still high when rst deasserts counts as burst start.

## Test plan
- Phase load, select 00: three words 16'h1234, 16'hABCD, 16'h0001, LSB first, back-to-back → phase_wr_en at cycles 17, 33, 49 after burst start with addr 0, 1, 2 and matching data; coeff_wr_en never asserts.
- Coefficient load, select 01: 4097 words of value i → coeff_wr_en for addr 0..4095 with data=i; word 4096 produces no strobe and load_overflow=1.
- Bypass load: adc_bypass_en=1 with word 16'h024F → adc_bypass_valid=1 and adc_bypass_data=16'h024F. Then run a select-00 burst → adc_bypass_data unchanged and phase writes start at addr 0.
- Abort and select-10: drop load_en after 9 bits → no write, next burst starts at addr 0 with a clean bit count. A select-10 burst of 2 words → no strobes and no overflow.
- Mid-burst changes: toggle sram_select 00→01 mid-burst → all writes stay on phase_wr_en. Assert rst during bit 12 of word 2 → outputs return to reset values, and the next burst writes addr 0.

Source files
------------

// File: rtl/sram_serial_loader_if.sv
// Serial load stream in, SRAM write strobes and ADC bypass word out.
// Master drives the bit stream; slave (the loader) drives the write side.
// No backpressure: every bit with load_en high is consumed on that edge.
interface sram_serial_loader_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 12
) ();
   logic                  load_en;
   logic                  serial_in;
   logic [1:0]            sram_select;
   logic                  adc_bypass_en;
   logic                  phase_wr_en;
   logic                  coeff_wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [DATA_WIDTH-1:0] adc_bypass_data;
   logic                  adc_bypass_valid;
   logic                  load_overflow;
   logic                  load_busy;

   modport master (
      output load_en, serial_in, sram_select, adc_bypass_en,
      input  phase_wr_en, coeff_wr_en, wr_addr, wr_data,
             adc_bypass_data, adc_bypass_valid, load_overflow, load_busy
   );

   modport slave (
      input  load_en, serial_in, sram_select, adc_bypass_en,
      output phase_wr_en, coeff_wr_en, wr_addr, wr_data,
             adc_bypass_data, adc_bypass_valid, load_overflow, load_busy
   );
endinterface

// File: rtl/sram_serial_loader.sv
// Deserializes the LSB-first load stream into words written to phase/coeff SRAM or the ADC bypass register.
// Latency: write strobe, address and data registered, valid the cycle after the last bit of a word is sampled.
// No backpressure: one bit per clock while load_en is high; out-of-range words set a sticky overflow flag.
module sram_serial_loader #(
   parameter int DATA_WIDTH  = 16,
   parameter int ADDR_WIDTH  = 12,
   parameter int PHASE_WORDS = 1275,
   parameter int COEFF_WORDS = 4096
) (
   input  logic               clk,
   input  logic               rst,
   sram_serial_loader_if.slave bus
);
   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
   // One extra address bit so a full 2^ADDR_WIDTH SRAM can be detected as full instead of wrapping.
   localparam logic [ADDR_WIDTH:0] PHASE_CAP = (ADDR_WIDTH + 1)'(PHASE_WORDS);
   localparam logic [ADDR_WIDTH:0] COEFF_CAP = (ADDR_WIDTH + 1)'(COEFF_WORDS);
   localparam logic [ADDR_WIDTH:0] ADDR_ONE  = (ADDR_WIDTH + 1)'(1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t                state;
   logic [DATA_WIDTH-2:0] shreg;      // bits received so far, newest at the top
   logic [CNT_W-1:0]      bit_cnt;
   logic [ADDR_WIDTH:0]   addr;
   logic                  tgt_bypass;
   logic [1:0]            tgt_sel;
   logic [DATA_WIDTH-1:0] word;

   // Word as it would stand if the current edge samples its final bit.
   assign word = {bus.serial_in, shreg};

   // Burst FSM, shifter, address counter and all registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state                <= IDLE;
         shreg                <= '0;
         bit_cnt              <= '0;
         addr                 <= '0;
         tgt_bypass           <= 1'b0;
         tgt_sel              <= 2'b00;
         bus.phase_wr_en      <= 1'b0;
         bus.coeff_wr_en      <= 1'b0;
         bus.wr_addr          <= '0;
         bus.wr_data          <= '0;
         bus.adc_bypass_data  <= '0;
         bus.adc_bypass_valid <= 1'b0;
         bus.load_overflow    <= 1'b0;
         bus.load_busy        <= 1'b0;
      end else begin
         bus.phase_wr_en <= 1'b0;
         bus.coeff_wr_en <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.load_en) begin
                  state         <= SHIFT;
                  bus.load_busy <= 1'b1;
                  tgt_bypass    <= bus.adc_bypass_en;
                  tgt_sel       <= bus.sram_select;
                  shreg         <= word[DATA_WIDTH-1:1];
                  bit_cnt       <= CNT_W'(1);
                  addr          <= '0;
               end
            end
            SHIFT: begin
               if (!bus.load_en) begin
                  // Any partially shifted word is simply dropped here.
                  state         <= IDLE;
                  bus.load_busy <= 1'b0;
                  bit_cnt       <= '0;
                  addr          <= '0;
               end else begin
                  shreg   <= word[DATA_WIDTH-1:1];
                  bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + CNT_W'(1);
                  if (bit_cnt == LAST_BIT) begin
                     if (tgt_bypass) begin
                        bus.adc_bypass_data  <= word;
                        bus.adc_bypass_valid <= 1'b1;
                     end else begin
                        case (tgt_sel)
                           2'b00: begin
                              if (addr < PHASE_CAP) begin
                                 bus.phase_wr_en <= 1'b1;
                                 bus.wr_addr     <= addr[ADDR_WIDTH-1:0];
                                 bus.wr_data     <= word;
                                 addr            <= addr + ADDR_ONE;
                              end else begin
                                 bus.load_overflow <= 1'b1;
                              end
                           end
                           2'b01: begin
                              if (addr < COEFF_CAP) begin
                                 bus.coeff_wr_en <= 1'b1;
                                 bus.wr_addr     <= addr[ADDR_WIDTH-1:0];
                                 bus.wr_data     <= word;
                                 addr            <= addr + ADDR_ONE;
                              end else begin
                                 bus.load_overflow <= 1'b1;
                              end
                           end
                           // Output SRAMs are not loadable: word is discarded.
                           default: ;
                        endcase
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
